// File: rtl/logic_chunks_pkg.sv
// ============================================================================
// Module      : logic_chunks_pkg
// Description : Shared FSM state encodings and types for truth_table_checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package logic_chunks_pkg;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_WAIT  = 2'd1;
    localparam logic [1:0] C_ST_CHECK = 2'd2;
    localparam logic [1:0] C_ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = C_ST_IDLE,
        S_WAIT  = C_ST_WAIT,
        S_CHECK = C_ST_CHECK,
        S_DONE  = C_ST_DONE
    } tt_state_e;

endpackage

`default_nettype wire

// File: rtl/truth_table_checker_settle.sv
// ============================================================================
// Module      : settle_timer
// Description : Counts cycles while enabled; expired flags the last one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserted during the SETTLE-th enabled cycle, so the caller leaves on that edge.
    assign expired = enable && (count_q == CW'(SETTLE - 1));

endmodule

`default_nettype wire

// File: rtl/truth_table_checker.sv
// ============================================================================
// Module      : truth_table_checker
// Description : Sweeps every input vector of a gate and counts output mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_checker
    import logic_chunks_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [(1<<N_IN)-1:0]  expected_tt,
    output logic [N_IN-1:0]       dut_in,
    input  logic                  dut_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [N_IN:0]         fail_count,
    output logic [N_IN-1:0]       first_fail_vec
);

    localparam int              NV       = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);

    tt_state_e         state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [NV-1:0]     tt_q, tt_d;
    logic [N_IN:0]     fail_count_q, fail_count_d;
    logic [N_IN-1:0]   first_fail_q, first_fail_d;
    logic              pass_q, pass_d;

    logic              w_settle_expired;
    logic              w_in_wait;
    logic              w_mismatch;

    assign w_in_wait  = (state_q == S_WAIT);
    assign w_mismatch = (dut_out != tt_q[vec_q]);

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!w_in_wait),
        .enable  (w_in_wait),
        .expired (w_settle_expired)
    );

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        tt_d         = tt_q;
        fail_count_d = fail_count_q;
        first_fail_d = first_fail_q;
        pass_d       = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tt_d         = expected_tt;
                    vec_d        = '0;
                    fail_count_d = '0;
                    first_fail_d = '0;
                    pass_d       = 1'b0;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_settle_expired) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_mismatch) begin
                    fail_count_d = fail_count_q + 1'b1;
                    if (fail_count_q == '0) begin
                        first_fail_d = vec_q;
                    end
                end
                // pass is resolved here so it appears together with done.
                if (vec_q == LAST_VEC) begin
                    pass_d  = (fail_count_d == '0);
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                vec_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vec_q        <= '0;
            tt_q         <= '0;
            fail_count_q <= '0;
            first_fail_q <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            tt_q         <= tt_d;
            fail_count_q <= fail_count_d;
            first_fail_q <= first_fail_d;
            pass_q       <= pass_d;
        end
    end

    assign dut_in         = vec_q;
    assign busy           = (state_q == S_WAIT) || (state_q == S_CHECK);
    assign done           = (state_q == S_DONE);
    assign pass           = pass_q;
    assign fail_count     = fail_count_q;
    assign first_fail_vec = first_fail_q;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_checker.sv
// ============================================================================
// Module      : tb_truth_table_checker
// Description : Scoreboard bench for truth_table_checker (SETTLE=1 and SETTLE=3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_truth_table_checker;

    localparam int N_IN = 2;
    localparam int NV   = 1 << N_IN;

    typedef struct {
        bit pass;
        int fc;
        int ffv;
        int done_edge;
    } exp_t;

    logic clk;
    logic rst_n;
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Instance A: SETTLE=1, AND or OR gate attached
    logic            start_a;
    logic [NV-1:0]   tt_a;
    logic [N_IN-1:0] din_a;
    logic            dout_a;
    logic            busy_a, done_a, pass_a;
    logic [N_IN:0]   fc_a;
    logic [N_IN-1:0] ffv_a;
    logic            gate_or;

    // Instance B: SETTLE=3, AND gate attached
    logic            start_b;
    logic [NV-1:0]   tt_b;
    logic [N_IN-1:0] din_b;
    logic            dout_b;
    logic            busy_b, done_b, pass_b;
    logic [N_IN:0]   fc_b;
    logic [N_IN-1:0] ffv_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   k_a = 0, k_b = 0;
    int   done_cnt_a = 0, done_cnt_b = 0;
    int   busy_cnt_a = 0, busy_cnt_b = 0;

    assign dout_a = gate_or ? (|din_a) : (&din_a);
    assign dout_b = &din_b;

    truth_table_checker #(.N_IN(N_IN), .SETTLE(1)) u_dut_a (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start_a),
        .expected_tt    (tt_a),
        .dut_in         (din_a),
        .dut_out        (dout_a),
        .busy           (busy_a),
        .done           (done_a),
        .pass           (pass_a),
        .fail_count     (fc_a),
        .first_fail_vec (ffv_a)
    );

    truth_table_checker #(.N_IN(N_IN), .SETTLE(3)) u_dut_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start_b),
        .expected_tt    (tt_b),
        .dut_in         (din_b),
        .dut_out        (dout_b),
        .busy           (busy_b),
        .done           (done_b),
        .pass           (pass_b),
        .fail_count     (fc_b),
        .first_fail_vec (ffv_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor A
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt_a = 0;
            end else begin
                if (busy_a) begin
                    busy_cnt_a++;
                    chk("dut_in_a", din_a, (edge_cnt - k_a) / 2);
                end
                if (done_a) begin
                    if (q_a.size() == 0) begin
                        chk("spurious_done_a", done_a, 0);
                    end else begin
                        e = q_a.pop_front();
                        chk("done_edge_a", edge_cnt, e.done_edge);
                        chk("pass_a", pass_a, e.pass);
                        chk("fail_count_a", fc_a, e.fc);
                        if (e.fc != 0) chk("first_fail_a", ffv_a, e.ffv);
                        chk("busy_cycles_a", busy_cnt_a, 2 * NV);
                    end
                    busy_cnt_a = 0;
                    done_cnt_a++;
                end
            end
        end
    end

    // Monitor B
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt_b = 0;
            end else begin
                if (busy_b) begin
                    busy_cnt_b++;
                    chk("dut_in_b", din_b, (edge_cnt - k_b) / 4);
                end
                if (done_b) begin
                    if (q_b.size() == 0) begin
                        chk("spurious_done_b", done_b, 0);
                    end else begin
                        e = q_b.pop_front();
                        chk("done_edge_b", edge_cnt, e.done_edge);
                        chk("pass_b", pass_b, e.pass);
                        chk("fail_count_b", fc_b, e.fc);
                        if (e.fc != 0) chk("first_fail_b", ffv_b, e.ffv);
                        chk("busy_cycles_b", busy_cnt_b, 4 * NV);
                    end
                    busy_cnt_b = 0;
                    done_cnt_b++;
                end
            end
        end
    end

    // Called at #1 after a rising edge; the next edge accepts the start.
    task automatic go_a(input logic [NV-1:0] tt, input bit use_or, input bit p,
                        input int fc, input int ffv, input bit push);
        exp_t e;
        gate_or = use_or;
        tt_a    = tt;
        start_a = 1'b1;
        k_a     = edge_cnt + 1;
        if (push) begin
            e.pass = p; e.fc = fc; e.ffv = ffv; e.done_edge = k_a + 2 * NV;
            q_a.push_back(e);
        end
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic go_b(input logic [NV-1:0] tt, input bit p, input int fc, input int ffv);
        exp_t e;
        tt_b    = tt;
        start_b = 1'b1;
        k_b     = edge_cnt + 1;
        e.pass = p; e.fc = fc; e.ffv = ffv; e.done_edge = k_b + 4 * NV;
        q_b.push_back(e);
        @(posedge clk); #1;
        start_b = 1'b0;
    endtask

    task automatic wait_done_a(input int prev);
        int t = 0;
        while (done_cnt_a == prev && t < 40) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("timeout_a", int'(done_cnt_a != prev), 1);
    endtask

    task automatic wait_done_b(input int prev);
        int t = 0;
        while (done_cnt_b == prev && t < 60) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("timeout_b", int'(done_cnt_b != prev), 1);
    endtask

    task automatic check_hold_a(input bit p, input int fc);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_pass_a", pass_a, p);
        chk("hold_fc_a", fc_a, fc);
        chk("idle_busy_a", busy_a, 0);
    endtask

    initial begin
        int prev;
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        tt_a    = '0;
        tt_b    = '0;
        gate_or = 1'b0;
        #2;
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_fc", fc_a, 0);
        chk("rst_ffv", ffv_a, 0);
        chk("rst_din", din_a, 0);
        chk("rst_busy_b", busy_b, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // AND gate, correct table
        prev = done_cnt_a;
        go_a(4'b1000, 1'b0, 1'b1, 0, 0, 1'b1);
        wait_done_a(prev);
        check_hold_a(1'b1, 0);

        // OR gate, correct table
        prev = done_cnt_a;
        go_a(4'b1110, 1'b1, 1'b1, 0, 0, 1'b1);
        wait_done_a(prev);
        check_hold_a(1'b1, 0);

        // AND gate, OR table: vectors 1 and 2 mismatch
        prev = done_cnt_a;
        go_a(4'b1110, 1'b0, 1'b0, 2, 1, 1'b1);
        wait_done_a(prev);
        check_hold_a(1'b0, 2);
        chk("hold_ffv_a", ffv_a, 1);

        // Every vector mismatches: fail_count reaches 2**N_IN
        prev = done_cnt_a;
        go_a(4'b0111, 1'b0, 1'b0, 4, 0, 1'b1);
        wait_done_a(prev);
        check_hold_a(1'b0, 4);

        // Start re-asserted mid-sweep, in last CHECK and in DONE; table toggled
        prev = done_cnt_a;
        go_a(4'b1000, 1'b0, 1'b1, 0, 0, 1'b1);
        repeat (2) @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        tt_a    = 4'b0111;
        repeat (4) @(posedge clk); #1;
        start_a = 1'b1;
        repeat (2) @(posedge clk); #1;
        start_a = 1'b0;
        repeat (15) @(posedge clk); #1;
        chk("single_done_a", done_cnt_a - prev, 1);
        chk("ignored_pass_a", pass_a, 1);
        chk("ignored_fc_a", fc_a, 0);

        // Reset mid-sweep
        prev = done_cnt_a;
        go_a(4'b0111, 1'b0, 1'b0, 0, 0, 1'b0);
        repeat (4) @(posedge clk); #1;
        chk("pre_rst_fc_a", fc_a, 2);
        chk("pre_rst_din_a", din_a, 2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy_a, 0);
        chk("async_rst_done", done_a, 0);
        chk("async_rst_pass", pass_a, 0);
        chk("async_rst_fc", fc_a, 0);
        chk("async_rst_ffv", ffv_a, 0);
        chk("async_rst_din", din_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk); #1;
        chk("no_done_after_rst", done_cnt_a - prev, 0);
        chk("idle_after_rst", busy_a, 0);
        prev = done_cnt_a;
        go_a(4'b1000, 1'b0, 1'b1, 0, 0, 1'b1);
        wait_done_a(prev);

        // SETTLE=3 instance
        prev = done_cnt_b;
        go_b(4'b1000, 1'b1, 0, 0);
        wait_done_b(prev);
        prev = done_cnt_b;
        go_b(4'b1110, 1'b0, 2, 1);
        wait_done_b(prev);

        repeat (3) @(posedge clk); #1;
        chk("queue_a_empty", q_a.size(), 0);
        chk("queue_b_empty", q_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
